// File: rtl/tictactoe_bot.sv
// Tic-tac-toe computer opponent: selects a target cell and drives the game's move/attack buttons.
// Ports: clk, rst, enable, bot_id[1:0], board_flat[17:0], cur_row/cur_col[1:0] -> move, attack, busy, done, err.
module tictactoe_bot #(
    parameter int PULSE_LEN    = 1,
    parameter int GAP_LEN      = 2,
    parameter int THINK_CYCLES = 4,
    parameter int MAX_STEPS    = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  bot_id,
    input  logic [17:0] board_flat,
    input  logic [1:0]  cur_row,
    input  logic [1:0]  cur_col,
    output logic        move,
    output logic        attack,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [3:0] {
        S_IDLE, S_THINK, S_PICK, S_CHECK, S_MOVE,
        S_MGAP, S_ATTACK, S_AGAP, S_WAIT
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  step_q, step_d;
    logic [3:0]  tgt_q, tgt_d;
    logic        move_q, move_d;
    logic        attack_q, attack_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    // Cell k (0..2) of line l: rows 0-2, columns 3-5, diagonals 6-7.
    function automatic int lcell(input int l, input int k);
        if (l < 3) return 3 * l + k;
        if (l < 6) return (l - 3) + 3 * k;
        if (l == 6) return 4 * k;
        return 2 + 2 * k;
    endfunction

    // Empty cells whose two line-mates both hold mark p.
    function automatic logic [8:0] line_fill(input logic [17:0] b,
                                             input logic [1:0] p);
        logic [8:0] m;
        int x, y, z;
        m = '0;
        for (int l = 0; l < 8; l++) begin
            for (int k = 0; k < 3; k++) begin
                x = lcell(l, k);
                y = lcell(l, (k + 1) % 3);
                z = lcell(l, (k + 2) % 3);
                if (b[2*x +: 2] == 2'b00 && b[2*y +: 2] == p &&
                    b[2*z +: 2] == p)
                    m[x] = 1'b1;
            end
        end
        return m;
    endfunction

    // Lowest set index; scanning downward lets the lowest index win.
    function automatic logic [3:0] first_set(input logic [8:0] m);
        logic [3:0] r;
        r = '0;
        for (int i = 8; i >= 0; i--)
            if (m[i]) r = 4'(i);
        return r;
    endfunction

    logic [8:0] empty, win_m, blk_m, pri_m;
    logic [3:0] pick_idx, cur_idx;
    logic       at_target;

    always_comb begin
        for (int i = 0; i < 9; i++)
            empty[i] = (board_flat[2*i +: 2] == 2'b00);
        win_m = line_fill(board_flat, bot_id);
        blk_m = line_fill(board_flat, 2'd3 - bot_id);
        if (|win_m)         pri_m = win_m;
        else if (|blk_m)    pri_m = blk_m;
        else if (empty[4])  pri_m = 9'b000010000;
        else if (|(empty & 9'b101000101))
                            pri_m = empty & 9'b101000101;
        else                pri_m = empty & 9'b010101010;
        pick_idx = first_set(pri_m);
    end

    // A zero on either axis never matches any cell.
    always_comb begin
        cur_idx   = ({2'b00, cur_row} - 4'd1) * 4'd3
                  + {2'b00, cur_col} - 4'd1;
        at_target = (cur_row != 2'd0) && (cur_col != 2'd0)
                  && (cur_idx == tgt_q);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step_d  = step_q;
        tgt_d   = tgt_q;
        err_d   = err_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (enable && !err_q) begin
                    state_d = S_THINK;
                    cnt_d   = '0;
                end
            end
            S_THINK: begin
                if (!enable) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == 8'(THINK_CYCLES - 1)) begin
                    state_d = S_PICK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_PICK: begin
                if (~|empty) begin
                    err_d   = 1'b1;
                    state_d = S_WAIT;
                end else begin
                    tgt_d   = pick_idx;
                    step_d  = '0;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (at_target) begin
                    state_d = S_ATTACK;
                end else if (step_q == 8'(MAX_STEPS)) begin
                    err_d   = 1'b1;
                    state_d = S_WAIT;
                end else begin
                    state_d = S_MOVE;
                end
                cnt_d = '0;
            end
            S_MOVE: begin
                if (cnt_q == 8'(PULSE_LEN - 1)) begin
                    step_d  = step_q + 8'd1;
                    cnt_d   = '0;
                    state_d = S_MGAP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_MGAP: begin
                if (cnt_q == 8'(GAP_LEN - 1)) begin
                    cnt_d   = '0;
                    state_d = S_CHECK;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_ATTACK: begin
                if (cnt_q == 8'(PULSE_LEN - 1)) begin
                    cnt_d   = '0;
                    state_d = S_AGAP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_AGAP: begin
                if (cnt_q == 8'(GAP_LEN - 1)) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = S_WAIT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_WAIT: begin
                if (!enable) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        move_d   = (state_d == S_MOVE);
        attack_d = (state_d == S_ATTACK);
        busy_d   = (state_d != S_IDLE) && (state_d != S_WAIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            step_q   <= '0;
            tgt_q    <= '0;
            move_q   <= 1'b0;
            attack_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            step_q   <= step_d;
            tgt_q    <= tgt_d;
            move_q   <= move_d;
            attack_q <= attack_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign move   = move_q;
    assign attack = attack_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;

endmodule

// File: tb/tb_tictactoe_bot.sv
// Directed bench for tictactoe_bot with a behavioural model of the game cursor.
// Counts pulses per turn and compares against hand-computed targets and latencies.
module tb_tictactoe_bot;

    localparam int THINK = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [1:0]  bot_id;
    logic [17:0] board_flat;
    logic [1:0]  cur_row, cur_col;
    logic        move, attack, busy, done, err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int t0, mv_n, at_n, dn_n, both_n, first_p, err_c, at_idx;
    bit frozen, finished, busy0;

    always #5 clk = ~clk;

    tictactoe_bot dut (
        .clk(clk), .rst(rst), .enable(enable), .bot_id(bot_id),
        .board_flat(board_flat), .cur_row(cur_row), .cur_col(cur_col),
        .move(move), .attack(attack), .busy(busy), .done(done),
        .err(err)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One cycle: sample outputs at the falling edge, then let the game
    // react to a move pulse the way the real cursor logic does.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (move) mv_n++;
        if (attack) begin
            at_n++;
            at_idx = (int'(cur_row) - 1) * 3 + int'(cur_col) - 1;
        end
        if (done) dn_n++;
        if (move && attack) both_n++;
        if ((move || attack) && first_p < 0) first_p = cyc - t0;
        if (err && err_c < 0) err_c = cyc - t0;
        if (move && !frozen) begin
            if (cur_col == 2'd3) begin
                cur_col = 2'd1;
                cur_row = (cur_row == 2'd3) ? 2'd1 : cur_row + 2'd1;
            end else begin
                cur_col = cur_col + 2'd1;
            end
        end
    endtask

    function automatic logic [17:0] put(input logic [17:0] b, input int r,
                                        input int c, input logic [1:0] v);
        b[2*((r-1)*3 + c - 1) +: 2] = v;
        return b;
    endfunction

    task automatic run_turn(input logic [17:0] b, input logic [1:0] bot,
                            input logic [1:0] r, input logic [1:0] c,
                            input bit frz);
        board_flat = b;
        bot_id = bot;
        cur_row = r;
        cur_col = c;
        frozen = frz;
        mv_n = 0; at_n = 0; dn_n = 0; both_n = 0;
        first_p = -1; err_c = -1; at_idx = -1;
        finished = 1'b0;
        enable = 1'b1;
        t0 = cyc + 1;
        tick();
        busy0 = busy;
        for (int i = 0; i < 200; i++) begin
            if (dn_n > 0 || err) begin
                finished = 1'b1;
                break;
            end
            tick();
        end
        chk("turn_finished", int'(finished), 1);
    endtask

    task automatic release_turn();
        enable = 1'b0;
        repeat (3) tick();
    endtask

    logic [17:0] b;

    initial begin
        rst = 1'b1; enable = 1'b0; bot_id = 2'b10;
        board_flat = '0; cur_row = 2'd1; cur_col = 2'd1;
        frozen = 1'b0; t0 = 0;
        mv_n = 0; at_n = 0; dn_n = 0; both_n = 0;
        first_p = -1; err_c = -1; at_idx = -1;
        repeat (3) tick();
        chk("rst_move", int'(move), 0);
        chk("rst_attack", int'(attack), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        rst = 1'b0;
        tick();

        // Empty board: center chosen, 4 steps from (1,1).
        run_turn('0, 2'b10, 2'd1, 2'd1, 1'b0);
        chk("empty_busy_think", int'(busy0), 1);
        chk("empty_moves", mv_n, 4);
        chk("empty_attacks", at_n, 1);
        chk("empty_target", at_idx, 4);
        chk("empty_done", dn_n, 1);
        chk("empty_err", int'(err), 0);
        chk("empty_latency", first_p, THINK + 2);
        chk("empty_overlap", both_n, 0);
        repeat (20) tick();
        chk("hold_no_rerun_mv", mv_n, 4);
        chk("hold_no_rerun_at", at_n, 1);
        chk("hold_busy", int'(busy), 0);
        release_turn();

        // Win at (1,3) beats block at (2,3).
        b = '0;
        b = put(b, 1, 1, 2'b10); b = put(b, 1, 2, 2'b10);
        b = put(b, 2, 1, 2'b01); b = put(b, 2, 2, 2'b01);
        run_turn(b, 2'b10, 2'd1, 2'd1, 1'b0);
        chk("win_moves", mv_n, 2);
        chk("win_attacks", at_n, 1);
        chk("win_target", at_idx, 2);
        chk("win_done", dn_n, 1);
        release_turn();

        // Block the diagonal at (3,3) where the cursor already sits.
        b = '0;
        b = put(b, 1, 1, 2'b01); b = put(b, 2, 2, 2'b01);
        b = put(b, 2, 1, 2'b10);
        run_turn(b, 2'b10, 2'd3, 2'd3, 1'b0);
        chk("block_moves", mv_n, 0);
        chk("block_attacks", at_n, 1);
        chk("block_target", at_idx, 8);
        chk("block_latency", first_p, THINK + 2);
        release_turn();

        // Center taken: corner (1,1) from (1,2) needs 8 wrapping steps.
        b = put(18'd0, 2, 2, 2'b01);
        run_turn(b, 2'b10, 2'd1, 2'd2, 1'b0);
        chk("corner_moves", mv_n, 8);
        chk("corner_target", at_idx, 0);
        chk("corner_err", int'(err), 0);
        release_turn();

        // Cursor row 0 never matches until it wraps into the grid.
        run_turn('0, 2'b10, 2'd0, 2'd1, 1'b0);
        chk("zero_moves", mv_n, 7);
        chk("zero_target", at_idx, 4);
        release_turn();

        // Full board: error one cycle after PICK, no pulses.
        run_turn(18'h15555, 2'b10, 2'd1, 2'd1, 1'b0);
        chk("full_moves", mv_n, 0);
        chk("full_attacks", at_n, 0);
        chk("full_err", int'(err), 1);
        chk("full_err_latency", err_c, THINK + 1);
        chk("full_busy_wait", int'(busy), 0);
        release_turn();
        enable = 1'b1;
        repeat (20) tick();
        chk("err_blocks_busy", int'(busy), 0);
        chk("err_blocks_moves", mv_n, 0);
        chk("err_sticky", int'(err), 1);
        enable = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("err_cleared", int'(err), 0);

        // Frozen cursor: step limit reached, no attack.
        run_turn('0, 2'b10, 2'd1, 2'd1, 1'b1);
        chk("frozen_moves", mv_n, 9);
        chk("frozen_attacks", at_n, 0);
        chk("frozen_err", int'(err), 1);
        enable = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        frozen = 1'b0;
        tick();

        // Reset during a move pulse.
        board_flat = '0; cur_row = 2'd1; cur_col = 2'd1;
        mv_n = 0; first_p = -1; t0 = cyc + 1;
        enable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (move) break;
            tick();
        end
        chk("pre_rst_move", int'(move), 1);
        rst = 1'b1;
        tick();
        chk("midrst_move", int'(move), 0);
        chk("midrst_busy", int'(busy), 0);
        enable = 1'b0;
        rst = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
